// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatter and write-back mux.
// Extracts and extends the load from the raw memory word, flags misaligned or
// illegal loads, selects the write-back source and registers it for the
// register file with stall/flush control. One cycle of latency.
// Optional feature: define WB_RETIRE_CNT_EN to build the retired-instruction
// counter; otherwise WB_retire_cnt_o is tied to zero.
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_valid_i,
  input  logic                  MEM_RegWrite_i,
  input  logic                  MEM_MemRead_i,
  input  logic [1:0]            MEM_wb_sel_i,
  input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rd_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  input  logic [DATA_WIDTH-1:0] MEM_imm_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  WB_valid_o,
  output logic                  WB_RegWrite_o,
  output logic [REG_ADDR_W-1:0] WB_rd_addr_o,
  output logic [DATA_WIDTH-1:0] WB_wr_data_o,
  output logic                  WB_load_misalign_o,
  output logic [CNT_WIDTH-1:0]  WB_retire_cnt_o
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [1:0]            offset;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_bad;
  logic                  misalign;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  unused_instr_bits;

  assign funct3            = MEM_instruction_i[14:12];
  assign rd_addr           = MEM_instruction_i[7 +: REG_ADDR_W];
  assign offset            = MEM_alu_result_i[1:0];
  assign unused_instr_bits = ^{MEM_instruction_i[DATA_WIDTH-1:15], MEM_instruction_i[6:0]};

  // Pick the addressed byte lane out of the word-aligned memory word
  always_comb begin
    byte_lane = MEM_rd_data_i[7:0];
    case (offset)
      2'd1:    byte_lane = MEM_rd_data_i[15:8];
      2'd2:    byte_lane = MEM_rd_data_i[23:16];
      2'd3:    byte_lane = MEM_rd_data_i[31:24];
      default: byte_lane = MEM_rd_data_i[7:0];
    endcase
  end

  assign half_lane = offset[1] ? MEM_rd_data_i[31:16] : MEM_rd_data_i[15:0];

  // Extend the selected lane per funct3 and note unaligned or illegal load encodings
  always_comb begin
    load_data = '0;
    load_bad  = 1'b0;
    case (funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LH: begin
        load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
        load_bad  = offset[0];
      end
      F3_LW: begin
        load_data = MEM_rd_data_i;
        load_bad  = (offset != 2'b00);
      end
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_LHU: begin
        load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
        load_bad  = offset[0];
      end
      default: begin
        load_data = '0;
        load_bad  = 1'b1;
      end
    endcase
  end

  assign misalign = MEM_MemRead_i & load_bad;
  assign wr_en    = MEM_valid_i & MEM_RegWrite_i & (rd_addr != '0) & ~misalign;

  // Write-back source selection
  always_comb begin
    wb_data = MEM_imm_i;
    case (MEM_wb_sel_i)
      SEL_ALU:  wb_data = MEM_alu_result_i;
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = MEM_pc_plus4_i;
      default:  wb_data = MEM_imm_i;
    endcase
  end

  // WB register: flush beats stall, stall holds, an invalid slot becomes a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_valid_o         <= 1'b0;
      WB_RegWrite_o      <= 1'b0;
      WB_rd_addr_o       <= '0;
      WB_wr_data_o       <= '0;
      WB_load_misalign_o <= 1'b0;
    end else if (flush_i || (!stall_i && !MEM_valid_i)) begin
      WB_valid_o         <= 1'b0;
      WB_RegWrite_o      <= 1'b0;
      WB_rd_addr_o       <= '0;
      WB_wr_data_o       <= '0;
      WB_load_misalign_o <= 1'b0;
    end else if (!stall_i) begin
      WB_valid_o         <= 1'b1;
      WB_RegWrite_o      <= wr_en;
      WB_rd_addr_o       <= rd_addr;
      WB_wr_data_o       <= wb_data;
      WB_load_misalign_o <= misalign;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_WIDTH-1:0] retire_cnt;

  // Count instructions that actually enter WB cleanly; wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!flush_i && !stall_i && MEM_valid_i && !misalign) begin
      retire_cnt <= retire_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign WB_retire_cnt_o = retire_cnt;
`else
  assign WB_retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven directed vectors, an async-reset-during-stall
// sequence and a randomized run against a behavioural model of mem_wb_stage.
module tb_mem_wb_stage;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic [1:0]  sel;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        misalign;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        MEM_valid_i;
  logic        MEM_RegWrite_i;
  logic        MEM_MemRead_i;
  logic [1:0]  MEM_wb_sel_i;
  logic [31:0] MEM_instruction_i;
  logic [31:0] MEM_alu_result_i;
  logic [31:0] MEM_rd_data_i;
  logic [31:0] MEM_pc_plus4_i;
  logic [31:0] MEM_imm_i;
  logic        stall_i;
  logic        flush_i;
  logic        WB_valid_o;
  logic        WB_RegWrite_o;
  logic [4:0]  WB_rd_addr_o;
  logic [31:0] WB_wr_data_o;
  logic        WB_load_misalign_o;
  logic [31:0] WB_retire_cnt_o;

  int checks = 0;
  int errors = 0;

  exp_t        modelQ;
  logic [31:0] modelCnt;
  vec_t        vecs[16];

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .CNT_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .MEM_valid_i        (MEM_valid_i),
    .MEM_RegWrite_i     (MEM_RegWrite_i),
    .MEM_MemRead_i      (MEM_MemRead_i),
    .MEM_wb_sel_i       (MEM_wb_sel_i),
    .MEM_instruction_i  (MEM_instruction_i),
    .MEM_alu_result_i   (MEM_alu_result_i),
    .MEM_rd_data_i      (MEM_rd_data_i),
    .MEM_pc_plus4_i     (MEM_pc_plus4_i),
    .MEM_imm_i          (MEM_imm_i),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .WB_valid_o         (WB_valid_o),
    .WB_RegWrite_o      (WB_RegWrite_o),
    .WB_rd_addr_o       (WB_rd_addr_o),
    .WB_wr_data_o       (WB_wr_data_o),
    .WB_load_misalign_o (WB_load_misalign_o),
    .WB_retire_cnt_o    (WB_retire_cnt_o)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(logic v, logic rw, logic mr, logic [1:0] sel,
                                   logic [31:0] instr, logic [31:0] alu, logic [31:0] rdata,
                                   logic [31:0] pc4, logic [31:0] imm, logic st, logic fl);
    stim_t s;
    s.valid = v; s.regwrite = rw; s.memread = mr; s.sel = sel; s.instr = instr;
    s.alu = alu; s.rdata = rdata; s.pc4 = pc4; s.imm = imm; s.stall = st; s.flush = fl;
    return s;
  endfunction

  function automatic exp_t mkExp(logic v, logic rw, logic [4:0] rd, logic [31:0] data, logic mis);
    exp_t e;
    e.valid = v; e.regwrite = rw; e.rd = rd; e.data = data; e.misalign = mis;
    return e;
  endfunction

  // Reference: what the WB register should hold after one edge with stimulus s
  function automatic exp_t modelNext(stim_t s, exp_t cur);
    exp_t        e;
    int          off;
    logic [2:0]  f3;
    logic [31:0] shifted;
    logic [31:0] loadVal;
    logic        bad;
    e   = mkExp(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    off = int'(s.alu[1:0]);
    f3  = s.instr[14:12];
    bad = 1'b0;
    loadVal = 32'd0;
    if (s.flush) return e;
    if (s.stall) return cur;
    if (!s.valid) return e;
    case (f3)
      3'd0: begin shifted = s.rdata >> (8 * off);       loadVal = 32'($signed(shifted[7:0])); end
      3'd1: begin shifted = s.rdata >> (16 * (off / 2)); loadVal = 32'($signed(shifted[15:0])); bad = (off % 2) != 0; end
      3'd2: begin loadVal = s.rdata; bad = (off != 0); end
      3'd4: begin shifted = s.rdata >> (8 * off);       loadVal = 32'(shifted[7:0]); end
      3'd5: begin shifted = s.rdata >> (16 * (off / 2)); loadVal = 32'(shifted[15:0]); bad = (off % 2) != 0; end
      default: begin loadVal = 32'd0; bad = 1'b1; end
    endcase
    e.valid    = 1'b1;
    e.rd       = s.instr[11:7];
    e.misalign = s.memread && bad;
    e.regwrite = s.regwrite && (e.rd != 5'd0) && !e.misalign;
    case (s.sel)
      2'd0: e.data = s.alu;
      2'd1: e.data = loadVal;
      2'd2: e.data = s.pc4;
      default: e.data = s.imm;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] expectedCount();
`ifdef WB_RETIRE_CNT_EN
    return modelCnt;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one stimulus at the falling edge, then settle just past the next rising edge
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    MEM_valid_i       = s.valid;
    MEM_RegWrite_i    = s.regwrite;
    MEM_MemRead_i     = s.memread;
    MEM_wb_sel_i      = s.sel;
    MEM_instruction_i = s.instr;
    MEM_alu_result_i  = s.alu;
    MEM_rd_data_i     = s.rdata;
    MEM_pc_plus4_i    = s.pc4;
    MEM_imm_i         = s.imm;
    stall_i           = s.stall;
    flush_i           = s.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (WB_valid_o !== e.valid) begin
      errors++; $display("[TB] FAIL %s valid: got %b expected %b", name, WB_valid_o, e.valid);
    end
    checks++;
    if (WB_RegWrite_o !== e.regwrite) begin
      errors++; $display("[TB] FAIL %s RegWrite: got %b expected %b", name, WB_RegWrite_o, e.regwrite);
    end
    checks++;
    if (WB_rd_addr_o !== e.rd) begin
      errors++; $display("[TB] FAIL %s rd: got %0d expected %0d", name, WB_rd_addr_o, e.rd);
    end
    checks++;
    if (WB_wr_data_o !== e.data) begin
      errors++; $display("[TB] FAIL %s data: got %h expected %h", name, WB_wr_data_o, e.data);
    end
    checks++;
    if (WB_load_misalign_o !== e.misalign) begin
      errors++; $display("[TB] FAIL %s misalign: got %b expected %b", name, WB_load_misalign_o, e.misalign);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] expCnt);
    checks++;
    if (WB_retire_cnt_o !== expCnt) begin
      errors++; $display("[TB] FAIL %s retire_cnt: got %0d expected %0d", name, WB_retire_cnt_o, expCnt);
    end
  endtask

  // Main sequence: reset, directed table, reset during stall, randomized run
  initial begin
    exp_t  zero;
    stim_t s;
    zero = mkExp(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    vecs[0]  = '{s: mkStim(1,1,1,2'd1,32'h0000_0283,32'h0000_1003,32'h80FF_1234,32'h0,32'h0,0,0), e: mkExp(1,1,5'd5,32'hFFFF_FF80,0)};
    vecs[1]  = '{s: mkStim(1,1,1,2'd1,32'h0000_5303,32'h0000_1002,32'h8001_7F00,32'h0,32'h0,0,0), e: mkExp(1,1,5'd6,32'h0000_8001,0)};
    vecs[2]  = '{s: mkStim(1,1,1,2'd1,32'h0000_1383,32'h0000_1001,32'h8001_7F00,32'h0,32'h0,0,0), e: mkExp(1,0,5'd7,32'h0000_7F00,1)};
    vecs[3]  = '{s: mkStim(1,1,0,2'd0,32'h0000_0033,32'h0000_0055,32'h0,32'h0,32'h0,0,0),        e: mkExp(1,0,5'd0,32'h0000_0055,0)};
    vecs[4]  = '{s: mkStim(1,1,0,2'd2,32'h0000_00EF,32'h0000_0777,32'h0,32'h104,32'h0,0,0),      e: mkExp(1,1,5'd1,32'h0000_0104,0)};
    vecs[5]  = '{s: mkStim(1,1,0,2'd3,32'h0000_0137,32'h0000_0888,32'h0,32'h0,32'hABCD_E000,0,0), e: mkExp(1,1,5'd2,32'hABCD_E000,0)};
    vecs[6]  = '{s: mkStim(1,1,0,2'd0,32'h0000_01B3,32'h0000_1111,32'h0,32'h0,32'h0,1,0),        e: mkExp(1,1,5'd2,32'hABCD_E000,0)};
    vecs[7]  = '{s: mkStim(1,1,1,2'd1,32'h0000_0283,32'h0000_2000,32'hFFFF_FFFF,32'h0,32'h0,1,0), e: mkExp(1,1,5'd2,32'hABCD_E000,0)};
    vecs[8]  = '{s: mkStim(0,0,0,2'd2,32'h0000_01B3,32'h0000_3333,32'h0,32'h500,32'h0,1,0),      e: mkExp(1,1,5'd2,32'hABCD_E000,0)};
    vecs[9]  = '{s: mkStim(1,1,1,2'd1,32'h0000_2503,32'h0000_2000,32'hDEAD_BEEF,32'h0,32'h0,1,1), e: zero};
    vecs[10] = '{s: mkStim(0,1,0,2'd0,32'h0000_0233,32'h0000_0099,32'h0,32'h0,32'h0,0,0),        e: zero};
    vecs[11] = '{s: mkStim(1,1,1,2'd1,32'h0000_3403,32'h0000_2000,32'h1234_5678,32'h0,32'h0,0,0), e: mkExp(1,0,5'd8,32'h0000_0000,1)};
    vecs[12] = '{s: mkStim(1,1,0,2'd0,32'h0000_34B3,32'h0000_0003,32'h0,32'h0,32'h0,0,0),        e: mkExp(1,1,5'd9,32'h0000_0003,0)};
    vecs[13] = '{s: mkStim(1,1,1,2'd1,32'h0000_2503,32'h0000_2000,32'hDEAD_BEEF,32'h0,32'h0,0,0), e: mkExp(1,1,5'd10,32'hDEAD_BEEF,0)};
    vecs[14] = '{s: mkStim(1,1,1,2'd1,32'h0000_4583,32'h0000_0001,32'h0000_9A00,32'h0,32'h0,0,0), e: mkExp(1,1,5'd11,32'h0000_009A,0)};
    vecs[15] = '{s: mkStim(1,1,1,2'd1,32'h0000_2603,32'h0000_2002,32'h1234_5678,32'h0,32'h0,0,0), e: mkExp(1,0,5'd12,32'h1234_5678,1)};

    rst = 1'b1;
    MEM_valid_i = 0; MEM_RegWrite_i = 0; MEM_MemRead_i = 0; MEM_wb_sel_i = 2'd0;
    MEM_instruction_i = 0; MEM_alu_result_i = 0; MEM_rd_data_i = 0;
    MEM_pc_plus4_i = 0; MEM_imm_i = 0; stall_i = 0; flush_i = 0;
    modelQ = zero;
    modelCnt = 32'd0;

    #12;
    checkOutput("reset", zero);
    checkCount("reset", 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Capture an instruction, stall, then hit reset while the stall is held
    applyStimulus(vecs[5].s);
    checkOutput("pre_stall_capture", vecs[5].e);
    applyStimulus(vecs[6].s);
    checkOutput("stall_hold", vecs[5].e);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_mid_stall", zero);
    checkCount("reset_mid_stall", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stall_i = 1'b0;
    modelQ = zero;
    modelCnt = 32'd0;

    for (int i = 0; i < 400; i++) begin
      exp_t nxt;
      s.valid    = ($urandom_range(0, 99) < 85);
      s.regwrite = ($urandom_range(0, 99) < 80);
      s.memread  = $urandom_range(0, 1) == 1;
      s.sel      = 2'($urandom_range(0, 3));
      s.instr    = $urandom;
      if ($urandom_range(0, 7) == 0) s.instr[11:7] = 5'd0;
      if (s.memread && $urandom_range(0, 3) != 0) s.instr[14:12] = 3'($urandom_range(0, 2));
      s.alu      = $urandom;
      s.rdata    = $urandom;
      s.pc4      = $urandom;
      s.imm      = $urandom;
      s.stall    = ($urandom_range(0, 99) < 20);
      s.flush    = ($urandom_range(0, 99) < 10);
      nxt = modelNext(s, modelQ);
      if (!s.flush && !s.stall && s.valid && !nxt.misalign) modelCnt = modelCnt + 32'd1;
      modelQ = nxt;
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", i), modelQ);
      checkCount($sformatf("rand%0d", i), expectedCount());
    end

    // Reset asserted mid-stream clears the counter and the register
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("final_reset", zero);
    checkCount("final_reset", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
